// File: rtl/br_wb_arbiter.sv
// rtl/br_wb_arbiter.sv - round-robin writeback arbiter for the register bank write port
// Two requesters (ALU, load) share one registered write stage; writes to r0 are dropped.
module br_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    output logic [ADDR_W-1:0] W_register,
    output logic [DATA_W-1:0] W_data,
    output logic              RegEn,
    input  logic [ADDR_W-1:0] R_register_1,
    input  logic [ADDR_W-1:0] R_register_2,
    output logic              hazard_1,
    output logic              hazard_2,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_M = 1'b1;

    logic              last_grant;
    logic              a_pick;
    logic              m_pick;
    logic              xfer;
    logic              both_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_live;

    assign both_valid = a_valid && m_valid;

    // Contention goes to whoever did not win last; reset leaves M as last so A wins first.
    always_comb begin
        a_pick = 1'b0;
        m_pick = 1'b0;
        if (!rst && !hold) begin
            if (both_valid) begin
                a_pick = (last_grant == GRANT_M);
                m_pick = (last_grant == GRANT_A);
            end else begin
                a_pick = a_valid;
                m_pick = m_valid;
            end
        end
    end

    assign a_ready  = a_pick;
    assign m_ready  = m_pick;
    assign xfer     = a_pick || m_pick;
    assign sel_addr = m_pick ? m_addr : a_addr;
    assign sel_data = m_pick ? m_data : a_data;
    assign sel_live = xfer && (sel_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant   <= GRANT_M;
            RegEn        <= 1'b0;
            W_register   <= '0;
            W_data       <= '0;
            conflict_cnt <= '0;
        end else begin
            RegEn <= sel_live;
            if (sel_live) begin
                W_register <= sel_addr;
                W_data     <= sel_data;
            end
            if (xfer) begin
                last_grant <= m_pick ? GRANT_M : GRANT_A;
            end
            if (both_valid && !hold && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

    // A read is unsafe while a matching write is staged or still being requested.
    assign hazard_1 = (R_register_1 != '0) &&
                      ((RegEn && (W_register == R_register_1)) ||
                       (a_valid && (a_addr == R_register_1)) ||
                       (m_valid && (m_addr == R_register_1)));

    assign hazard_2 = (R_register_2 != '0) &&
                      ((RegEn && (W_register == R_register_2)) ||
                       (a_valid && (a_addr == R_register_2)) ||
                       (m_valid && (m_addr == R_register_2)));

endmodule

// File: tb/tb_br_wb_arbiter.sv
// tb/tb_br_wb_arbiter.sv - self-checking bench for br_wb_arbiter
// Cycle model checked on every falling edge plus directed literal expectations.
module tb_br_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        m_valid = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [4:0]  R_register_1 = '0;
    logic [4:0]  R_register_2 = '0;

    logic        a_ready, m_ready, RegEn, hazard_1, hazard_2;
    logic [4:0]  W_register;
    logic [31:0] W_data;
    logic [15:0] conflict_cnt;

    logic        a_ready2, m_ready2, RegEn2, hazard_12, hazard_22;
    logic [4:0]  W_register2;
    logic [31:0] W_data2;
    logic [1:0]  conflict_cnt2;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    br_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
        .W_register(W_register), .W_data(W_data), .RegEn(RegEn),
        .R_register_1(R_register_1), .R_register_2(R_register_2),
        .hazard_1(hazard_1), .hazard_2(hazard_2), .conflict_cnt(conflict_cnt)
    );

    br_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready2),
        .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready2),
        .W_register(W_register2), .W_data(W_data2), .RegEn(RegEn2),
        .R_register_1(R_register_1), .R_register_2(R_register_2),
        .hazard_1(hazard_12), .hazard_2(hazard_22), .conflict_cnt(conflict_cnt2)
    );

    logic [31:0] bank [32];
    initial for (int i = 0; i < 32; i++) bank[i] = '0;
    always @(posedge clk) if (RegEn) bank[W_register] <= W_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model state: who won last, the staged write, and the uncapped contention count.
    bit          md_last_m;
    bit          md_wen;
    logic [4:0]  md_wreg;
    logic [31:0] md_wdata;
    int          md_cnt;

    function automatic int winner(input bit av, input bit mv, input bit last_m);
        if (av && mv) return last_m ? 1 : 2;
        if (av) return 1;
        if (mv) return 2;
        return 0;
    endfunction

    function automatic bit read_hazard(input logic [4:0] r);
        if (r == 0) return 1'b0;
        return (md_wen && md_wreg == r) || (a_valid && a_addr == r) || (m_valid && m_addr == r);
    endfunction

    always @(negedge clk) begin
        int w;
        logic [4:0] addr;
        if (rst) begin
            md_last_m = 1'b1;
            md_wen    = 1'b0;
            md_wreg   = '0;
            md_wdata  = '0;
            md_cnt    = 0;
        end
        w = (rst || hold) ? 0 : winner(a_valid, m_valid, md_last_m);
        check("a_ready", a_ready, w == 1);
        check("m_ready", m_ready, w == 2);
        check("RegEn", RegEn, md_wen);
        check("W_register", W_register, md_wreg);
        check("W_data", W_data, md_wdata);
        check("conflict_cnt", conflict_cnt, (md_cnt > 65535) ? 65535 : md_cnt);
        check("conflict_cnt_sat", conflict_cnt2, (md_cnt > 3) ? 3 : md_cnt);
        check("hazard_1", hazard_1, read_hazard(R_register_1));
        check("hazard_2", hazard_2, read_hazard(R_register_2));
        if (!rst) begin
            if (!hold && a_valid && m_valid) md_cnt++;
            md_wen = 1'b0;
            if (w != 0) begin
                md_last_m = (w == 2);
                addr = (w == 1) ? a_addr : m_addr;
                if (addr != 0) begin
                    md_wen   = 1'b1;
                    md_wreg  = addr;
                    md_wdata = (w == 1) ? a_data : m_data;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ai;
        int mi;
        tick();
        tick();
        check("rst_RegEn", RegEn, 0);
        check("rst_W_register", W_register, 0);
        check("rst_W_data", W_data, 0);
        check("rst_conflict_cnt", conflict_cnt, 0);
        rst = 1'b0;
        tick();

        // Round-robin: both valid for four edges, grants A, M, A, M.
        ai = 0; mi = 0;
        a_valid = 1'b1; a_addr = 5'd3;
        m_valid = 1'b1; m_addr = 5'd7;
        for (int i = 0; i < 4; i++) begin
            a_data = 32'hA000_0000 + ai;
            m_data = 32'hB000_0000 + mi;
            #1;
            check("rr_a_ready", a_ready, (i % 2) == 0);
            check("rr_m_ready", m_ready, (i % 2) == 1);
            tick();
            check("rr_RegEn", RegEn, 1);
            check("rr_W_register", W_register, (i % 2 == 0) ? 5'd3 : 5'd7);
            check("rr_W_data", W_data, (i % 2 == 0) ? 32'hA000_0000 + i / 2 : 32'hB000_0000 + i / 2);
            if (i % 2 == 0) ai++; else mi++;
        end
        a_valid = 1'b0; m_valid = 1'b0;
        #1;
        check("rr_conflict_cnt", conflict_cnt, 4);
        tick();
        check("rr_RegEn_drop", RegEn, 0);

        // Single requester, two-edge latency into the bank.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234_5678;
        #1;
        check("single_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        check("single_RegEn", RegEn, 1);
        check("single_W_register", W_register, 5);
        check("single_W_data", W_data, 32'h1234_5678);
        tick();
        check("single_bank5", bank[5], 32'h1234_5678);

        // Register-0 write is acknowledged and discarded.
        m_valid = 1'b1; m_addr = 5'd0; m_data = 32'hFFFF_FFFF;
        #1;
        check("r0_m_ready", m_ready, 1);
        tick();
        m_valid = 1'b0;
        check("r0_RegEn", RegEn, 0);
        check("r0_W_register", W_register, 5);
        check("r0_W_data", W_data, 32'h1234_5678);
        tick();
        check("r0_bank0", bank[0], 0);

        // Hazards: r9 pending from A, r0 from M never flags.
        R_register_1 = 5'd9; R_register_2 = 5'd0;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hCAFE_0009;
        m_valid = 1'b1; m_addr = 5'd0; m_data = 32'h0;
        #1;
        check("hz_h1_req", hazard_1, 1);
        check("hz_h2_r0", hazard_2, 0);
        check("hz_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        #1;
        check("hz_h1_staged", hazard_1, 1);
        check("hz_m_ready", m_ready, 1);
        tick();
        m_valid = 1'b0;
        #1;
        check("hz_h1_clear", hazard_1, 0);
        check("hz_bank9", bank[9], 32'hCAFE_0009);
        R_register_1 = 5'd0;

        // Hold freezes arbitration and the counter.
        hold = 1'b1;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h0000_0033;
        m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h0000_0077;
        #1;
        check("hold_a_ready", a_ready, 0);
        check("hold_m_ready", m_ready, 0);
        tick();
        tick();
        check("hold_RegEn", RegEn, 0);
        check("hold_conflict_cnt", conflict_cnt, 5);
        hold = 1'b0;
        #1;
        check("unhold_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        tick();
        m_valid = 1'b0;
        check("unhold_W_register", W_register, 7);
        tick();

        // Asynchronous reset kills a staged write without a clock edge.
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h0BAD_F00D;
        tick();
        a_valid = 1'b0;
        check("arst_RegEn_before", RegEn, 1);
        rst = 1'b1;
        #1;
        check("arst_RegEn_now", RegEn, 0);
        tick();
        rst = 1'b0;
        check("arst_W_register", W_register, 0);
        check("arst_W_data", W_data, 0);
        check("arst_conflict_cnt", conflict_cnt, 0);
        tick();

        // Six contended edges: the 2-bit counter pins at 3.
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
        m_valid = 1'b1; m_addr = 5'd2; m_data = 32'h2;
        for (int i = 0; i < 6; i++) tick();
        a_valid = 1'b0; m_valid = 1'b0;
        #1;
        check("sat_cnt2", conflict_cnt2, 3);
        check("sat_cnt16", conflict_cnt, 6);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
